// File: rtl/key_edge_pio_pkg.sv
// Shared constants for the key/switch input PIO: register addresses and
// edge-capture selection encodings.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/key_edge_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO, including its level irq.
interface key_edge_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/key_edge_pio_debounce.sv
// One input bit: two-flop synchronizer followed by a persistence debouncer
// that accepts a new level only after DEBOUNCE_CYCLES consecutive clocks.
module pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_d
);

    localparam int             CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_d;
    logic [CW-1:0] r_cnt;

    // Any clock where the synced level matches d restarts the count, so
    // glitches shorter than the window are discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1  <= IDLE_BIT;
            r_s2  <= IDLE_BIT;
            r_d   <= IDLE_BIT;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
            if (r_s2 != r_d) begin
                if (r_cnt == TC) begin
                    r_d   <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_d = r_d;

endmodule

// File: rtl/key_edge_pio.sv
// Avalon-MM input PIO: debounced keys/switches, sticky edge capture with
// write-1-to-clear, and a masked level irq.
module key_edge_pio
    import key_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    key_edge_pio_if.slave    avs
);

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_d_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_ecap;
    logic [31:0]      r_readdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_BIT        (IDLE_VALUE[g])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .i_in    (in_port[g]),
            .o_d     (w_d[g])
        );
    end

    assign w_rise = w_d & ~r_d_prev;
    assign w_fall = ~w_d & r_d_prev;

    always_comb begin
        w_event = '0;
        if (EDGE_TYPE == int'(EDGE_RISE))
            w_event = w_rise;
        else if (EDGE_TYPE == int'(EDGE_FALL))
            w_event = w_fall;
        else if (EDGE_TYPE == int'(EDGE_ANY))
            w_event = w_rise | w_fall;
    end

    assign w_wr           = avs.chipselect & ~avs.write_n;
    assign w_rd           = avs.chipselect & ~avs.read_n;
    assign w_clr          = (w_wr && avs.address == ADDR_EDGECAP) ? avs.writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^avs.writedata;

    always_comb begin
        w_rd_mux = '0;
        case (avs.address)
            ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_d;
            ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_ecap;
            default:      w_rd_mux = '0;
        endcase
    end

    // A new edge event overrides a same-cycle clear so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_prev   <= IDLE_VALUE;
            r_mask     <= '0;
            r_ecap     <= '0;
            r_readdata <= '0;
        end else begin
            r_d_prev <= w_d;
            if (w_wr && avs.address == ADDR_IRQMASK)
                r_mask <= avs.writedata[WIDTH-1:0];
            r_ecap <= (r_ecap & ~w_clr) | w_event;
            if (w_rd)
                r_readdata <= w_rd_mux;
        end
    end

    assign avs.readdata = r_readdata;
    assign avs.irq      = |(r_ecap & r_mask);

endmodule

// File: tb/tb_key_edge_pio.sv
// Randomized bench for key_edge_pio against a window-based behavioural model,
// plus directed scenarios with literal expectations.
module tb_key_edge_pio;
    import key_pio_pkg::*;

    localparam int         W    = 4;
    localparam int         DC   = 4;
    localparam int         ET   = 1;
    localparam logic [3:0] IDLE = 4'hF;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = IDLE;

    key_edge_pio_if bus();

    key_edge_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .EDGE_TYPE       (ET),
        .IDLE_VALUE      (IDLE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .avs     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: d flips once the last DC synchronized samples all
    // disagree with it; a falling d lands in edgecapture one clock later.
    logic [3:0]  hist [0:DC+1];
    logic [3:0]  m_d, m_mask, m_ecap, m_pend, m_clr, m_nd;
    logic [31:0] m_rd, m_rv;
    bit          m_stable;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= DC + 1; k++) hist[k] = IDLE;
            m_d = IDLE; m_mask = 4'h0; m_ecap = 4'h0; m_pend = 4'h0; m_rd = 32'h0;
        end else begin
            case (bus.address)
                2'd0:    m_rv = {28'h0, m_d};
                2'd2:    m_rv = {28'h0, m_mask};
                2'd3:    m_rv = {28'h0, m_ecap};
                default: m_rv = 32'h0;
            endcase
            if (bus.chipselect && !bus.read_n) m_rd = m_rv;
            m_clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
            m_ecap = (m_ecap & ~m_clr) | m_pend;
            for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = in_port;
            m_nd = m_d;
            for (int b = 0; b < W; b++) begin
                m_stable = 1'b1;
                for (int k = 2; k <= DC + 1; k++)
                    if (hist[k][b] == m_d[b]) m_stable = 1'b0;
                if (m_stable) m_nd[b] = ~m_d[b];
            end
            m_pend = m_d & ~m_nd;
            m_d    = m_nd;
        end
    end

    always @(negedge clk) begin
        chk("readdata", bus.readdata, m_rd);
        chk("irq", {31'h0, bus.irq}, {31'h0, |(m_ecap & m_mask)});
    end

    task automatic idle_bus();
        bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
        bus.address = 2'd0; bus.writedata = 32'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
        @(posedge clk); #1;
        idle_bus();
        d = bus.readdata;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] v;

    initial begin
        idle_bus();
        reset_n = 1'b0;
        in_port = IDLE;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(2'd0, v); chk("rst_data", v, 32'hF);
        rd(2'd2, v); chk("rst_mask", v, 32'h0);
        rd(2'd3, v); chk("rst_ecap", v, 32'h0);
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);

        // Key 1 pressed and held; continuous data reads expose exact latency.
        @(posedge clk); #1 in_port[1] = 1'b0;
        bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 2'd0;
        wait_clks(9);
        idle_bus();
        chk("press_data_last", bus.readdata, 32'hD);
        rd(2'd3, v); chk("press_ecap", v, 32'h2);
        chk("press_irq_masked", {31'h0, bus.irq}, 32'h0);

        wr(2'd2, 32'h2);
        chk("mask_irq", {31'h0, bus.irq}, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, v); chk("w1c_other", v, 32'h2);
        chk("w1c_other_irq", {31'h0, bus.irq}, 32'h1);
        wr(2'd3, 32'h2);
        rd(2'd3, v); chk("w1c_clear", v, 32'h0);
        chk("w1c_clear_irq", {31'h0, bus.irq}, 32'h0);

        in_port = IDLE;
        wait_clks(10);

        // Three-clock glitch on key 0 must be rejected.
        @(posedge clk); #1 in_port[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 in_port[0] = 1'b1;
        wait_clks(10);
        rd(2'd0, v); chk("glitch_data", v, 32'hF);
        rd(2'd3, v); chk("glitch_ecap", v, 32'h0);
        chk("glitch_irq", {31'h0, bus.irq}, 32'h0);

        // W1C of bit 2 on the very edge its falling event lands.
        wr(2'd2, 32'h4);
        @(posedge clk); #1 in_port[2] = 1'b0;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd3; bus.writedata = 32'h4;
        @(posedge clk); #1;
        idle_bus();
        rd(2'd3, v); chk("collide_ecap", v, 32'h4);
        chk("collide_irq", {31'h0, bus.irq}, 32'h1);
        wr(2'd3, 32'h4);
        in_port = IDLE;
        wait_clks(10);

        // Asynchronous reset with a pending capture and a debounce in progress.
        wr(2'd2, 32'h2);
        @(posedge clk); #1 in_port[1] = 1'b0;
        wait_clks(10);
        rd(2'd3, v); chk("pre_rst_ecap", v, 32'h2);
        chk("pre_rst_irq", {31'h0, bus.irq}, 32'h1);
        @(posedge clk); #1 in_port[3] = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_readdata", bus.readdata, 32'h0);
        chk("async_rst_irq", {31'h0, bus.irq}, 32'h0);
        in_port = IDLE;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_clks(12);
        rd(2'd3, v); chk("post_rst_ecap", v, 32'h0);
        rd(2'd0, v); chk("post_rst_data", v, 32'hF);
        rd(2'd2, v); chk("post_rst_mask", v, 32'h0);

        // Random keys and bus traffic, checked every cycle by the model.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) in_port = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0, 1: rd(2'($urandom_range(0, 3)), v);
                2:    wr(2'($urandom_range(0, 3)), $urandom);
                3:    wr(2'd3, 32'($urandom_range(0, 15)));
                default: wait_clks(1);
            endcase
        end
        wait_clks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule
